// File: rtl/trap_sequencer.sv
// Machine-mode interrupt entry/exit sequencer: priority select, pipeline drain, CSR update, fetch redirect, mret.
// Optional macro TRAP_VECTORED_EN enables vectored trap targets when mtvec[0]=1.
module trap_sequencer #(
   parameter int DRAIN_TIMEOUT = 15,
   parameter int CNT_W         = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] mtvec,
   input  logic        mstatus_mie,
   input  logic        mstatus_mpie,
   input  logic [31:0] mie,
   input  logic [31:0] mip,
   input  logic [31:0] mepc,
   input  logic [31:0] epc_in,
   input  logic        drain_done,
   input  logic        mret,
   input  logic        redirect_ready,
   output logic        stall_req,
   output logic        flush,
   output logic        trap_we,
   output logic [31:0] mepc_wdata,
   output logic [31:0] mcause_wdata,
   output logic        mie_next,
   output logic        mpie_next,
   output logic        mret_we,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   // state | meaning
   // IDLE  | watch for mret or an enabled pending interrupt
   // DRAIN | pipeline stalled, waiting for drain_done or timeout flush
   // SAVE  | one-cycle mepc/mcause/mstatus write strobe
   // REDIR | redirect fetch to the trap vector until accepted
   // MRET  | redirect fetch to mepc until accepted, MIE restored on entry
   typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_SAVE, S_REDIR, S_MRET} state_t;

   // Reserved interrupt bits 2, 6, 10 and 12..15 never cause a trap.
   localparam logic [31:0] IRQ_MASK = ~32'h0000_F444;

   state_t      state_q, state_d;
   logic [4:0]  cause_q, cause_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic        mie_taken_q, mie_taken_d;
   logic        stall_req_q, stall_req_d;
   logic        flush_q, flush_d;
   logic        trap_we_q, trap_we_d;
   logic        mret_we_q, mret_we_d;
   logic        mie_next_q, mie_next_d;
   logic        mpie_next_q, mpie_next_d;
   logic        redirect_valid_q, redirect_valid_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic [31:0] mepc_wdata_q, mepc_wdata_d;
   logic [31:0] mcause_wdata_q, mcause_wdata_d;

   logic [31:0] pending;
   logic        take;
   logic [4:0]  sel_cause;
   logic [31:0] trap_pc;

   // Later assignments win, so walk from lowest to highest priority.
   function automatic logic [4:0] pick_cause(input logic [31:0] p);
      logic [4:0] c;
      c = '0;
      for (int i = 31; i >= 16; i--) begin
         if (p[i]) c = 5'(i);
      end
      if (p[0])  c = 5'd0;
      if (p[4])  c = 5'd4;
      if (p[8])  c = 5'd8;
      if (p[1])  c = 5'd1;
      if (p[5])  c = 5'd5;
      if (p[9])  c = 5'd9;
      if (p[7])  c = 5'd7;
      if (p[3])  c = 5'd3;
      if (p[11]) c = 5'd11;
      return c;
   endfunction

   assign pending   = mip & mie & IRQ_MASK;
   assign take      = mstatus_mie & (|pending);
   assign sel_cause = pick_cause(pending);

`ifdef TRAP_VECTORED_EN
   assign trap_pc = mtvec[0] ? ({mtvec[31:2], 2'b00} + {25'b0, cause_q, 2'b00})
                             : {mtvec[31:2], 2'b00};
`else
   assign trap_pc = {mtvec[31:2], 2'b00};
`endif

   always_comb begin
      state_d          = state_q;
      cause_d          = cause_q;
      cnt_d            = cnt_q;
      mie_taken_d      = mie_taken_q;
      stall_req_d      = 1'b0;
      flush_d          = 1'b0;
      trap_we_d        = 1'b0;
      mret_we_d        = 1'b0;
      mie_next_d       = 1'b0;
      mpie_next_d      = 1'b0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      mepc_wdata_d     = mepc_wdata_q;
      mcause_wdata_d   = mcause_wdata_q;
      case (state_q)
         S_IDLE: begin
            redirect_pc_d = '0;
            if (mret) begin
               state_d          = S_MRET;
               mret_we_d        = 1'b1;
               mie_next_d       = mstatus_mpie;
               mpie_next_d      = 1'b1;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = {mepc[31:2], 2'b00};
            end else if (take) begin
               state_d     = S_DRAIN;
               cause_d     = sel_cause;
               cnt_d       = '0;
               mie_taken_d = mstatus_mie;
               stall_req_d = 1'b1;
            end
         end
         S_DRAIN: begin
            stall_req_d = 1'b1;
            // The flush cycle itself completes the drain.
            if (flush_q || drain_done) begin
               state_d        = S_SAVE;
               trap_we_d      = 1'b1;
               mpie_next_d    = mie_taken_q;
               mepc_wdata_d   = {epc_in[31:2], 2'b00};
               mcause_wdata_d = {1'b1, 26'b0, cause_q};
            end else if ((DRAIN_TIMEOUT != 0) && (cnt_q == CNT_W'(DRAIN_TIMEOUT))) begin
               flush_d = 1'b1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SAVE: begin
            state_d          = S_REDIR;
            stall_req_d      = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = trap_pc;
         end
         S_REDIR: begin
            if (redirect_ready) begin
               state_d       = S_IDLE;
               redirect_pc_d = '0;
            end else begin
               stall_req_d      = 1'b1;
               redirect_valid_d = 1'b1;
            end
         end
         S_MRET: begin
            if (redirect_ready) begin
               state_d       = S_IDLE;
               redirect_pc_d = '0;
            end else begin
               redirect_valid_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= S_IDLE;
         cause_q          <= '0;
         cnt_q            <= '0;
         mie_taken_q      <= 1'b0;
         stall_req_q      <= 1'b0;
         flush_q          <= 1'b0;
         trap_we_q        <= 1'b0;
         mret_we_q        <= 1'b0;
         mie_next_q       <= 1'b0;
         mpie_next_q      <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         mepc_wdata_q     <= '0;
         mcause_wdata_q   <= '0;
      end else begin
         state_q          <= state_d;
         cause_q          <= cause_d;
         cnt_q            <= cnt_d;
         mie_taken_q      <= mie_taken_d;
         stall_req_q      <= stall_req_d;
         flush_q          <= flush_d;
         trap_we_q        <= trap_we_d;
         mret_we_q        <= mret_we_d;
         mie_next_q       <= mie_next_d;
         mpie_next_q      <= mpie_next_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         mepc_wdata_q     <= mepc_wdata_d;
         mcause_wdata_q   <= mcause_wdata_d;
      end
   end

   assign stall_req      = stall_req_q;
   assign flush          = flush_q;
   assign trap_we        = trap_we_q;
   assign mret_we        = mret_we_q;
   assign mie_next       = mie_next_q;
   assign mpie_next      = mpie_next_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign mepc_wdata     = mepc_wdata_q;
   assign mcause_wdata   = mcause_wdata_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: interrupt entry, priority, drain timeout, mret, redirect backpressure, reset.
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [31:0] mtvec = '0;
   logic        mstatus_mie = 1'b0;
   logic        mstatus_mpie = 1'b0;
   logic [31:0] mie = '0;
   logic [31:0] mip = '0;
   logic [31:0] mepc = '0;
   logic [31:0] epc_in = '0;
   logic        drain_done = 1'b0;
   logic        mret = 1'b0;
   logic        redirect_ready = 1'b0;
   logic        stall_req, flush, trap_we, mie_next, mpie_next, mret_we, redirect_valid;
   logic [31:0] mepc_wdata, mcause_wdata, redirect_pc;

   int errors = 0;
   int checks = 0;

`ifdef TRAP_VECTORED_EN
   localparam bit VEC = 1'b1;
`else
   localparam bit VEC = 1'b0;
`endif

   localparam logic [31:0] PRI_VEC [6] = '{32'h0000_0888, 32'h0001_0011, 32'h0003_0000,
                                           32'h0000_0202, 32'h8000_0001, 32'h0000_00A0};
   localparam logic [4:0]  PRI_CAUSE [6] = '{5'd11, 5'd4, 5'd16, 5'd9, 5'd0, 5'd7};

   always #5 clk = ~clk;

   trap_sequencer #(.DRAIN_TIMEOUT(15), .CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .mtvec(mtvec), .mstatus_mie(mstatus_mie),
      .mstatus_mpie(mstatus_mpie), .mie(mie), .mip(mip), .mepc(mepc), .epc_in(epc_in),
      .drain_done(drain_done), .mret(mret), .redirect_ready(redirect_ready),
      .stall_req(stall_req), .flush(flush), .trap_we(trap_we), .mepc_wdata(mepc_wdata),
      .mcause_wdata(mcause_wdata), .mie_next(mie_next), .mpie_next(mpie_next),
      .mret_we(mret_we), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3 reset_n = 1'b0;
      #2;
      checks++;
      if ({stall_req, flush, trap_we, mret_we, redirect_valid, mie_next, mpie_next} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {stall_req, flush, trap_we, mret_we, redirect_valid, mie_next, mpie_next});
      end
      checks++;
      if ({redirect_pc, mepc_wdata, mcause_wdata} !== 96'b0) begin
         errors++;
         $display("FAIL reset_data: pc=%h mepc=%h mcause=%h want 0", redirect_pc, mepc_wdata, mcause_wdata);
      end
      tick();
      tick();
      reset_n = 1'b1;
      drain_done = 1'b1;
      redirect_ready = 1'b1;
      mstatus_mie = 1'b1;
      tick();
   endtask

   task automatic test_mti();
      mtvec = 32'h100;
      epc_in = 32'h0000_1236;
      mip = 32'h80;
      mie = 32'h80;
      tick();
      mip = '0;
      checks++;
      if (stall_req !== 1'b1 || trap_we !== 1'b0) begin
         errors++;
         $display("FAIL mti_drain: stall=%b trap_we=%b want 1 0", stall_req, trap_we);
      end
      tick();
      checks++;
      if (trap_we !== 1'b1 || mcause_wdata !== 32'h8000_0007 || mepc_wdata !== 32'h0000_1234) begin
         errors++;
         $display("FAIL mti_save: we=%b mcause=%h mepc=%h want 1 80000007 00001234",
                  trap_we, mcause_wdata, mepc_wdata);
      end
      checks++;
      if (mie_next !== 1'b0 || mpie_next !== 1'b1) begin
         errors++;
         $display("FAIL mti_mstatus: mie_next=%b mpie_next=%b want 0 1", mie_next, mpie_next);
      end
      tick();
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100 || trap_we !== 1'b0) begin
         errors++;
         $display("FAIL mti_redir: valid=%b pc=%h we=%b want 1 00000100 0", redirect_valid, redirect_pc, trap_we);
      end
      tick();
      checks++;
      if (redirect_valid !== 1'b0 || stall_req !== 1'b0) begin
         errors++;
         $display("FAIL mti_idle: valid=%b stall=%b want 0 0", redirect_valid, stall_req);
      end
   endtask

   task automatic test_priority();
      logic [31:0] exp_pc;
      mtvec = 32'h101;
      for (int i = 0; i < 6; i++) begin
         exp_pc = 32'h100 + (VEC ? {25'b0, PRI_CAUSE[i], 2'b00} : 32'h0);
         mip = PRI_VEC[i];
         mie = PRI_VEC[i];
         tick();
         mip = '0;
         tick();
         checks++;
         if (trap_we !== 1'b1 || mcause_wdata !== {1'b1, 26'b0, PRI_CAUSE[i]}) begin
            errors++;
            $display("FAIL prio_cause[%0d]: we=%b mcause=%h want 1 %h", i, trap_we, mcause_wdata,
                     {1'b1, 26'b0, PRI_CAUSE[i]});
         end
         tick();
         checks++;
         if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc) begin
            errors++;
            $display("FAIL prio_pc[%0d]: valid=%b pc=%h want 1 %h", i, redirect_valid, redirect_pc, exp_pc);
         end
         tick();
      end
   endtask

   task automatic test_no_take();
      mip = 32'h0000_F444;
      mie = 32'h0000_F444;
      tick();
      tick();
      checks++;
      if (stall_req !== 1'b0 || trap_we !== 1'b0) begin
         errors++;
         $display("FAIL masked_bits: stall=%b we=%b want 0 0", stall_req, trap_we);
      end
      mip = 32'h80;
      mie = 32'h80;
      mstatus_mie = 1'b0;
      tick();
      tick();
      checks++;
      if (stall_req !== 1'b0 || trap_we !== 1'b0) begin
         errors++;
         $display("FAIL mie_off: stall=%b we=%b want 0 0", stall_req, trap_we);
      end
      mip = '0;
      mstatus_mie = 1'b1;
   endtask

   task automatic test_timeout();
      int n;
      mtvec = 32'h100;
      drain_done = 1'b0;
      mip = 32'h8;
      mie = 32'h8;
      tick();
      n = 1;
      mip = '0;
      while (flush !== 1'b1 && n < 40) begin
         checks++;
         if (stall_req !== 1'b1 || trap_we !== 1'b0) begin
            errors++;
            $display("FAIL drain_stall: cycle=%0d stall=%b we=%b want 1 0", n, stall_req, trap_we);
         end
         tick();
         n++;
      end
      checks++;
      if (n != 17) begin
         errors++;
         $display("FAIL flush_time: flush at tick %0d want 17", n);
      end
      tick();
      checks++;
      if (trap_we !== 1'b1 || flush !== 1'b0 || mcause_wdata !== 32'h8000_0003) begin
         errors++;
         $display("FAIL timeout_save: we=%b flush=%b mcause=%h want 1 0 80000003", trap_we, flush, mcause_wdata);
      end
      drain_done = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_mret_vs_take();
      mepc = 32'h2000;
      mstatus_mpie = 1'b1;
      mip = 32'h80;
      mie = 32'h80;
      mret = 1'b1;
      tick();
      mret = 1'b0;
      checks++;
      if (mret_we !== 1'b1 || mie_next !== 1'b1 || mpie_next !== 1'b1) begin
         errors++;
         $display("FAIL mret_strobe: we=%b mie=%b mpie=%b want 1 1 1", mret_we, mie_next, mpie_next);
      end
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2000 || stall_req !== 1'b0) begin
         errors++;
         $display("FAIL mret_redir: valid=%b pc=%h stall=%b want 1 00002000 0", redirect_valid, redirect_pc, stall_req);
      end
      tick();
      checks++;
      if (mret_we !== 1'b0 || redirect_valid !== 1'b0 || stall_req !== 1'b0) begin
         errors++;
         $display("FAIL mret_idle: we=%b valid=%b stall=%b want 0 0 0", mret_we, redirect_valid, stall_req);
      end
      tick();
      mip = '0;
      checks++;
      if (stall_req !== 1'b1) begin
         errors++;
         $display("FAIL mret_then_take: stall=%b want 1", stall_req);
      end
      tick();
      checks++;
      if (trap_we !== 1'b1 || mcause_wdata !== 32'h8000_0007) begin
         errors++;
         $display("FAIL mret_then_save: we=%b mcause=%h want 1 80000007", trap_we, mcause_wdata);
      end
      tick();
      tick();
      mstatus_mpie = 1'b0;
   endtask

   task automatic test_redir_hold();
      mtvec = 32'h200;
      redirect_ready = 1'b0;
      mip = 32'h800;
      mie = 32'h800;
      tick();
      mip = '0;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         mret = (i == 1);
         checks++;
         if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200 || stall_req !== 1'b1 || mret_we !== 1'b0) begin
            errors++;
            $display("FAIL redir_hold[%0d]: valid=%b pc=%h stall=%b mret_we=%b want 1 00000200 1 0",
                     i, redirect_valid, redirect_pc, stall_req, mret_we);
         end
         tick();
      end
      mret = 1'b0;
      redirect_ready = 1'b1;
      checks++;
      if (redirect_valid !== 1'b1 || mret_we !== 1'b0) begin
         errors++;
         $display("FAIL redir_last: valid=%b mret_we=%b want 1 0", redirect_valid, mret_we);
      end
      tick();
      checks++;
      if (redirect_valid !== 1'b0 || stall_req !== 1'b0) begin
         errors++;
         $display("FAIL redir_release: valid=%b stall=%b want 0 0", redirect_valid, stall_req);
      end
   endtask

   task automatic test_reset_in_save();
      mip = 32'h80;
      mie = 32'h80;
      tick();
      mip = '0;
      tick();
      checks++;
      if (trap_we !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_save: we=%b want 1", trap_we);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({stall_req, flush, trap_we, mret_we, redirect_valid, mie_next, mpie_next} !== 7'b0 ||
          {redirect_pc, mepc_wdata, mcause_wdata} !== 96'b0) begin
         errors++;
         $display("FAIL rst_async: ctrl=%b pc=%h mepc=%h mcause=%h want all 0",
                  {stall_req, flush, trap_we, mret_we, redirect_valid, mie_next, mpie_next},
                  redirect_pc, mepc_wdata, mcause_wdata);
      end
      tick();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (trap_we !== 1'b0 || stall_req !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_release[%0d]: we=%b stall=%b valid=%b want 0 0 0",
                     i, trap_we, stall_req, redirect_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mti();
      test_priority();
      test_no_take();
      test_timeout();
      test_mret_vs_take();
      test_redir_hold();
      test_reset_in_save();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
